direccion_jugadores: RTL and testbench

DIRECCION_JUGADORES -- requirements
Module: direccion_jugadores

---
 rtl/direccion_jugadores.sv | 111 +++++++++++
 tb/tb_direccion_jugadores.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/direccion_jugadores.sv
// direccion_jugadores: per-player buffered direction commands applied to a
// direction/pause FSM once per movement tick.
module direccion_jugadores #(
  parameter int N_JUG       = 2,
  parameter int TICK_CICLOS = 4000000,
  parameter int PROF_FIFO   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reinicio,
  input  logic [N_JUG-1:0]   cmd_val,
  input  logic [3*N_JUG-1:0] cmd,
  output logic [3*N_JUG-1:0] accion,
  output logic               mover,
  output logic [N_JUG-1:0]   pausado,
  output logic [N_JUG-1:0]   fifo_lleno,
  output logic [N_JUG-1:0]   desborde
);
  localparam int CW = $clog2(TICK_CICLOS);
  localparam int AW = $clog2(PROF_FIFO);
  typedef enum logic [3:0] {
    INICIO, MOV_ARR, MOV_ABA, MOV_IZQ, MOV_DER, PAU_ARR, PAU_ABA, PAU_IZQ, PAU_DER
  } estado_t;
  logic [CW-1:0] cnt;
  logic          tick;
  assign tick = cnt == CW'(TICK_CICLOS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      mover <= 1'b0;
    end else if (reinicio) begin
      cnt   <= '0;
      mover <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + CW'(1);
      mover <= tick;
    end
  for (genvar i = 0; i < N_JUG; i++) begin : g_jug
    logic [2:0]    mem [PROF_FIFO];
    logic [AW-1:0] rp, wp;
    logic [AW:0]   n;
    logic [2:0]    cod, c, d, ac, ac_n;
    logic [3:0]    sv;
    logic          push, pop, lleno, acepta, des, es_dir, perp;
    estado_t       st, st_n;
    assign cod    = cmd[3*i +: 3];
    assign push   = cmd_val[i] && cod != 3'd0 && cod <= 3'd5;
    assign pop    = tick && n != '0;
    assign lleno  = n == (AW+1)'(PROF_FIFO);
    // a pop on the same edge frees the slot, so a push to a full buffer survives
    assign acepta = push && (!lleno || pop);
    assign c      = pop ? mem[rp] : 3'd0;
    assign sv     = st;
    assign d      = sv > 4'd4 ? 3'(sv - 4'd4) : sv[2:0];
    assign es_dir = c != 3'd0 && c < 3'd5;
    assign perp   = (c > 3'd2) != (d > 3'd2);
    always_comb begin
      st_n = st;
      ac_n = 3'd0;
      if (st == INICIO) begin
        if (es_dir) begin
          st_n = estado_t'({1'b0, c});
          ac_n = c;
        end
      end else if (st <= MOV_DER) begin
        ac_n = d;
        if (c == 3'd5) begin
          st_n = estado_t'(sv + 4'd4);
          ac_n = 3'd0;
        end else if (es_dir && perp) begin
          st_n = estado_t'({1'b0, c});
          ac_n = c;
        end
      end else if (c == 3'd5) begin
        st_n = estado_t'({1'b0, d});
        ac_n = d;
      end
    end
    always_ff @(posedge clk)
      if (acepta) mem[wp] <= cod;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rp  <= '0;
        wp  <= '0;
        n   <= '0;
        des <= 1'b0;
        st  <= INICIO;
        ac  <= 3'd0;
      end else if (reinicio) begin
        rp  <= '0;
        wp  <= '0;
        n   <= '0;
        des <= 1'b0;
        st  <= INICIO;
        ac  <= 3'd0;
      end else begin
        if (acepta) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
        n <= n + (AW+1)'(acepta) - (AW+1)'(pop);
        if (push && !acepta) des <= 1'b1;
        if (tick) begin
          st <= st_n;
          ac <= ac_n;
        end
      end
    assign accion[3*i +: 3] = ac;
    assign pausado[i]       = st > MOV_DER;
    assign fifo_lleno[i]    = lleno;
    assign desborde[i]      = des;
  end
endmodule

// File: tb/tb_direccion_jugadores.sv
// tb_direccion_jugadores: directed vectors for direccion_jugadores with a
// 2-player, 8-cycle tick, 4-deep buffer configuration.
module tb_direccion_jugadores;
  logic       clk = 1'b0, rst = 1'b1, reinicio = 1'b0;
  logic [1:0] cmd_val = '0;
  logic [5:0] cmd = '0;
  logic [5:0] accion;
  logic       mover;
  logic [1:0] pausado, fifo_lleno, desborde;
  int         errores = 0, checks = 0, ciclos = 0, ph = 0;
  logic       exp_mover = 1'b0;

  direccion_jugadores #(.N_JUG(2), .TICK_CICLOS(8), .PROF_FIFO(4)) dut (
    .clk(clk), .rst(rst), .reinicio(reinicio), .cmd_val(cmd_val), .cmd(cmd),
    .accion(accion), .mover(mover), .pausado(pausado),
    .fifo_lleno(fifo_lleno), .desborde(desborde)
  );

  always #5 clk = ~clk;

  // expected tick phase: counter value seen before each edge, and the mover it implies
  always @(posedge clk or posedge rst)
    if (rst || reinicio) begin
      ph        <= 0;
      exp_mover <= 1'b0;
    end else begin
      exp_mover <= ph == 7;
      ph        <= ph == 7 ? 0 : ph + 1;
    end

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errores++;
      $display("FAIL %s: obtenido=%0h esperado=%0h", tag, obs, exp);
    end
  endtask

  task automatic empujar(input int j, input logic [2:0] c);
    cmd_val[j]     = 1'b1;
    cmd[3*j +: 3]  = c;
    @(negedge clk);
    cmd_val = '0;
    cmd     = '0;
  endtask

  task automatic esperar_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!exp_mover) chequear("mover_reposo", 32'(mover), 0);
    end while (!exp_mover && k < 20);
    chequear("mover_tick", 32'(mover), 1);
  endtask

  task automatic esperar_fase(input int p);
    for (int k = 0; k < 20 && ph != p; k++) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chequear("rst_accion", 32'(accion), 0);
    chequear("rst_mover", 32'(mover), 0);
    chequear("rst_pausado", 32'(pausado), 0);
    chequear("rst_lleno", 32'(fifo_lleno), 0);
    chequear("rst_desborde", 32'(desborde), 0);
    rst = 1'b0;
    // first command and tick period
    empujar(0, 3'd4);
    esperar_tick(ciclos);
    chequear("t1_acc0", 32'(accion[2:0]), 4);
    chequear("t1_acc1", 32'(accion[5:3]), 0);
    esperar_tick(ciclos);
    chequear("periodo", 32'(ciclos), 8);
    chequear("acc_retenida", 32'(accion[2:0]), 4);
    // opposite ignored, perpendicular taken
    empujar(0, 3'd3);
    empujar(0, 3'd1);
    esperar_tick(ciclos);
    chequear("opuesto_ign", 32'(accion[2:0]), 4);
    esperar_tick(ciclos);
    chequear("perp_arr", 32'(accion[2:0]), 1);
    // pause / resume on player 1
    empujar(1, 3'd2);
    esperar_tick(ciclos);
    chequear("p1_aba", 32'(accion[5:3]), 2);
    chequear("p0_indep", 32'(accion[2:0]), 1);
    empujar(1, 3'd5);
    empujar(1, 3'd2);
    empujar(1, 3'd5);
    esperar_tick(ciclos);
    chequear("pau_acc", 32'(accion[5:3]), 0);
    chequear("pau_flag", 32'(pausado), 32'b10);
    esperar_tick(ciclos);
    chequear("pau_dir_acc", 32'(accion[5:3]), 0);
    chequear("pau_dir_flag", 32'(pausado), 32'b10);
    esperar_tick(ciclos);
    chequear("resume_acc", 32'(accion[5:3]), 2);
    chequear("resume_flag", 32'(pausado), 0);
    chequear("p0_sigue", 32'(accion[2:0]), 1);
    // fill player 0 buffer, invalid code, overflow
    empujar(0, 3'd3);
    empujar(0, 3'd4);
    empujar(0, 3'd3);
    empujar(0, 3'd4);
    chequear("lleno_4", 32'(fifo_lleno), 32'b01);
    chequear("sin_desb_4", 32'(desborde), 0);
    empujar(0, 3'd6);
    chequear("cod6_ign", 32'(desborde), 0);
    empujar(0, 3'd3);
    chequear("desb_5", 32'(desborde), 32'b01);
    chequear("lleno_5", 32'(fifo_lleno), 32'b01);
    // push on a full buffer during the tick itself is accepted
    esperar_fase(7);
    empujar(0, 3'd1);
    chequear("pushpop_mover", 32'(mover), 1);
    chequear("pushpop_acc", 32'(accion[2:0]), 3);
    chequear("pushpop_lleno", 32'(fifo_lleno), 32'b01);
    chequear("desb_sticky", 32'(desborde), 32'b01);
    // asynchronous reset mid-period with buffers non-empty
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chequear("arst_accion", 32'(accion), 0);
    chequear("arst_lleno", 32'(fifo_lleno), 0);
    chequear("arst_desborde", 32'(desborde), 0);
    chequear("arst_pausado", 32'(pausado), 0);
    chequear("arst_mover", 32'(mover), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    esperar_tick(ciclos);
    chequear("arst_periodo", 32'(ciclos), 7);
    chequear("arst_pop_vacio", 32'(accion), 0);
    // synchronous restart on a tick cycle with a concurrent push
    for (int k = 0; k < 5; k++) empujar(1, 3'd1);
    chequear("p1_desb", 32'(desborde), 32'b10);
    chequear("p1_lleno", 32'(fifo_lleno), 32'b10);
    esperar_fase(7);
    reinicio      = 1'b1;
    cmd_val[0]    = 1'b1;
    cmd[2:0]      = 3'd4;
    @(negedge clk);
    reinicio = 1'b0;
    cmd_val  = '0;
    cmd      = '0;
    chequear("rein_mover", 32'(mover), 0);
    chequear("rein_accion", 32'(accion), 0);
    chequear("rein_lleno", 32'(fifo_lleno), 0);
    chequear("rein_desborde", 32'(desborde), 0);
    esperar_tick(ciclos);
    chequear("rein_periodo", 32'(ciclos), 8);
    chequear("rein_push_perdido", 32'(accion), 0);
    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end
endmodule
